// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
//
// Purpose:
//   Shares one BRAM port (Port B) between two requesters.  A request is
//   sampled only in IDLE; the winner's id, byte strobes, address and write
//   data are captured at that moment.  The BRAM strobe is issued for exactly
//   one cycle (ISSUE).  Writes complete in the following cycle (DONE), while
//   reads wait READ_LAT cycles (WAIT_RD) before the BRAM output is captured.
//   A one-cycle ack pulse goes to the granted requester in DONE.
//
//   Arbitration is round-robin by default: on a tie the requester that was
//   not granted last wins, and requester 0 wins the first tie after reset.
//   Defining the macro BRAM_ARB_FIXED_PRIO_EN selects fixed priority instead
//   (requester 0 always wins a tie, no last-granted state is kept).
//
// Parameters:
//   READ_LAT   cycles from the bram_en cycle to the cycle whose end samples
//              bram_dout (legal range 1..3, default 2)
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   req0/req1          access requests, held high until the matching ack
//   we0/we1    [3:0]   byte write strobes, 4'b0000 = read
//   addr0/addr1[31:0]  byte addresses (word aligned on the BRAM side)
//   wdata0/1   [31:0]  write data
//   ack0/ack1          one-cycle completion pulses (never both high)
//   rdata      [31:0]  read data, valid in the ack cycle, held until the next
//                      read capture
//   busy               high in every state except IDLE
//   bram_clk/bram_rst  copies of clk/rst for the BRAM port
//   bram_en/we/addr/din  registered BRAM Port B controls
//   bram_dout  [31:0]  BRAM Port B read data
// -----------------------------------------------------------------------------
module bram_port_arbiter #(
   parameter int READ_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic [3:0]  we0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   input  logic        req1,
   input  logic [3:0]  we1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        bram_clk,
   output logic        bram_rst,
   output logic        bram_en,
   output logic [3:0]  bram_we,
   output logic [31:0] bram_addr,
   output logic [31:0] bram_din,
   input  logic [31:0] bram_dout
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2,
      DONE    = 2'd3
   } state_t;

   // Terminal value of the WAIT_RD cycle counter.
   localparam logic [1:0] LAST_CNT = 2'(READ_LAT - 1);

   state_t      state_q;
   state_t      state_d;
   logic [1:0]  wait_cnt_q;
   logic [1:0]  wait_cnt_d;

   // Captured transaction attributes.  Address and write data live directly
   // in bram_addr / bram_din, which are loaded at grant time and never
   // touched again until the next grant.
   logic        gnt_id_q;
   logic [3:0]  lat_we_q;

   logic        any_req;
   logic        win_id;
   logic [3:0]  win_we;
   logic [31:0] win_addr;
   logic [31:0] win_wdata;

   logic        grant;
   logic        en_d;
   logic [3:0]  we_d;
   logic        finish;
   logic        capture;

   // Byte offset bits are dropped when the address is aligned to a word.
   logic        unused_addr_bits;
   assign unused_addr_bits = ^{addr0[1:0], addr1[1:0]};

   assign bram_clk = clk;
   assign bram_rst = rst;
   assign busy     = (state_q != IDLE);
   assign any_req  = req0 | req1;

   // --------------------------------------------------------------------------
   // Winner selection
   // --------------------------------------------------------------------------
`ifdef BRAM_ARB_FIXED_PRIO_EN
   // Requester 0 takes any tie; requester 1 only wins when alone.
   assign win_id = ~req0;
`else
   logic last_gnt_q;

   // On a tie the requester not granted last wins; otherwise the single
   // active requester wins (req1 high alone -> 1, req0 high alone -> 0).
   assign win_id = (req0 && req1) ? ~last_gnt_q : req1;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_gnt_q <= 1'b1;
      end else if (grant) begin
         last_gnt_q <= win_id;
      end
   end
`endif

   assign win_we    = win_id ? we1    : we0;
   assign win_addr  = win_id ? addr1  : addr0;
   assign win_wdata = win_id ? wdata1 : wdata0;

   // --------------------------------------------------------------------------
   // FSM state register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         wait_cnt_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // --------------------------------------------------------------------------
   // FSM next state and next-cycle output values
   // --------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      grant      = 1'b0;
      en_d       = 1'b0;
      we_d       = 4'b0000;
      finish     = 1'b0;
      capture    = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Requests are looked at only here; anything raised and dropped
            // while busy is never seen.
            if (any_req) begin
               grant   = 1'b1;
               en_d    = 1'b1;
               we_d    = win_we;
               state_d = ISSUE;
            end
         end

         ISSUE: begin
            wait_cnt_d = 2'd0;
            if (lat_we_q == 4'b0000) begin
               state_d = WAIT_RD;
            end else begin
               finish  = 1'b1;
               state_d = DONE;
            end
         end

         WAIT_RD: begin
            if (wait_cnt_q == LAST_CNT) begin
               capture = 1'b1;
               finish  = 1'b1;
               state_d = DONE;
            end else begin
               wait_cnt_d = wait_cnt_q + 2'd1;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Registered BRAM controls, captured transaction, ack and read data
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         bram_en   <= 1'b0;
         bram_we   <= 4'b0000;
         bram_addr <= 32'd0;
         bram_din  <= 32'd0;
         rdata     <= 32'd0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         gnt_id_q  <= 1'b0;
         lat_we_q  <= 4'b0000;
      end else begin
         // bram_we is driven only together with bram_en, so it reads as zero
         // in every cycle without a strobe.
         bram_en <= en_d;
         bram_we <= we_d;
         // Acks are registered from finish, so they land in DONE and only
         // the granted requester can see one.
         ack0    <= finish & ~gnt_id_q;
         ack1    <= finish &  gnt_id_q;

         if (grant) begin
            gnt_id_q  <= win_id;
            lat_we_q  <= win_we;
            bram_addr <= {win_addr[31:2], 2'b00};
            bram_din  <= win_wdata;
         end

         if (capture) begin
            rdata <= bram_dout;
         end
      end
   end

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameter READ_LAT, default 2, SHALL set the number of cycles from the bram_en cycle to the cycle whose end samples bram_dout (legal 1..3).
REQ-002 clk  input  1  SHALL be the single clock for all logic; reset is synchronous and active-high.
REQ-003 rst  input  1  SHALL be the synchronous active-high reset.
REQ-004 reqN  input  1 (N=0,1)  SHALL be the access request, held high until ackN.
REQ-005 weN  input  4 (N=0,1)  SHALL be the byte write strobes; 4'b0000 means read.
REQ-006 addrN  input  32 (N=0,1)  SHALL be the byte address.
REQ-007 wdataN  input  32 (N=0,1)  SHALL be the write data.
REQ-008 ackN  output  1 (N=0,1)  SHALL be the one-cycle completion pulse.
REQ-009 rdata  output  32  SHALL be the read data, valid in the ack cycle.
REQ-010 busy  output  1  SHALL be high in every state except IDLE.
REQ-011 bram_clk, bram_rst  output  1 each  SHALL equal clk and rst.
REQ-012 bram_en, bram_we[3:0], bram_addr[31:0], bram_din[31:0]  output  SHALL be registered BRAM Port B controls.
REQ-013 bram_dout  input  32  SHALL be BRAM Port B read data.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT_RD, DONE.
REQ-015 IDLE: if any reqN is high, the arbiter SHALL latch the winner's id, we, addr and wdata and move to ISSUE; otherwise it SHALL stay in IDLE.
REQ-016 Round-robin: with both requests high, the arbiter SHALL grant the requester not granted last; with one request high, it SHALL grant that requester.
REQ-017 ISSUE: bram_en SHALL be 1 for exactly this cycle, with bram_we = latched we, bram_addr = {addr[31:2],2'b00} and bram_din = wdata.
REQ-018 The FSM SHALL go ISSUE->DONE for writes and ISSUE->WAIT_RD for reads.
REQ-019 WAIT_RD SHALL last READ_LAT cycles, capture bram_dout into rdata at the end of the last one, then go to DONE.
REQ-020 DONE SHALL pulse ack of the granted requester for one cycle and go to IDLE; rdata SHALL hold until the next read capture.
REQ-021 Latency from request sampled in IDLE to ack SHALL be 2 cycles for a write and 2+READ_LAT cycles for a read.
REQ-022 The arbiter SHALL ignore request inputs in every state except IDLE.
REQ-023 A requester SHALL be allowed to change addrN, weN or wdataN after grant without effect.
REQ-024 bram_we SHALL be 4'b0000 whenever bram_en is 0.
REQ-025 A request dropped before being sampled in IDLE SHALL produce no access and no ack.
REQ-026 Only one ackN SHALL be high in any cycle.

Reset
REQ-027 Reset SHALL set state IDLE, bram_en 0, bram_we 0, bram_addr 0, bram_din 0, rdata 0, ack0/ack1 0 and busy 0, and SHALL record requester 1 as last granted so requester 0 wins the first tie.
REQ-028 Reset during any non-IDLE state SHALL abort the access with no ack issued and no further BRAM strobes.

Configuration
REQ-029 With BRAM_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win a tie and no last-granted state SHALL exist; without the macro, arbitration SHALL be round-robin per REQ-016.

Verification
REQ-030 Write: req0 with we0=4'hF, addr0=0x4 and wdata0=0xDEADBEEF -> one cycle of bram_en=1, bram_we=4'hF, bram_addr=0x4, bram_din=0xDEADBEEF; ack0 2 cycles after sampling.
REQ-031 Read with READ_LAT=2, BRAM word 0x0 = 0x1 -> ack1 4 cycles after sampling, rdata=0x00000001, bram_we=0 throughout.
REQ-032 Both requests held continuously for 4 accesses -> grant order 0,1,0,1 (round-robin); 0,0,0,0 with BRAM_ARB_FIXED_PRIO_EN.
REQ-033 rst asserted in WAIT_RD -> next cycle state IDLE, no ack, bram_en=0; the following tie is granted to requester 0.
REQ-034 addr0=0x7 -> bram_addr=0x4.
REQ-035 req1 high for one cycle during a requester-0 access, then low -> no requester-1 access and no ack1.
